// File: rtl/nest_setup_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// nest_setup_ctrl_pkg
// Shared parameters for the nest setup sequencer and its bounds helper.
// The playfield coordinate widths, the playfield extent and the nest radius
// live here so nests, food sources and the setup sequencer all use the same
// geometry. The sequencer state type is also defined here.
// -----------------------------------------------------------------------------
package nest_setup_ctrl_pkg;

  // Coordinate widths of the playfield.
  localparam int X_bits = 10;
  localparam int Y_bits = 10;

  // Largest legal coordinate on each axis.
  localparam int X_MAX = 639;
  localparam int Y_MAX = 479;

  // A nest must keep this clearance from every playfield edge.
  localparam int NEST_RADIUS = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PROBE,
    CHECK,
    COMMIT,
    DONE,
    FAIL
  } nest_setup_state_t;

  // Counter width for values 0..n-1. A single-valued counter still gets
  // one bit so the port and flop declarations stay legal.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : nest_setup_ctrl_pkg

// File: rtl/nest_setup_ctrl_bounds_check.sv
// -----------------------------------------------------------------------------
// bounds_check
// Purely combinational margin compare. It flags a coordinate that lies
// closer than MARGIN to any playfield edge. The setup sequencer uses it for
// nests, and food-source placement can reuse it with its own margin.
//
// Ports
//   x              in  XW  candidate x (unsigned)
//   y              in  YW  candidate y (unsigned)
//   out_of_bounds  out 1   high when x or y falls inside the edge margin
// -----------------------------------------------------------------------------
module bounds_check
  import nest_setup_ctrl_pkg::*;
#(
  parameter int XW     = X_bits,
  parameter int YW     = Y_bits,
  parameter int X_LIM  = X_MAX,
  parameter int Y_LIM  = Y_MAX,
  parameter int MARGIN = NEST_RADIUS
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic          out_of_bounds
);

  // The limits are sized to the coordinate width, so every compare below is
  // unsigned at the same width as the coordinate.
  localparam logic [XW-1:0] X_LO = XW'(MARGIN);
  localparam logic [XW-1:0] X_HI = XW'(X_LIM - MARGIN);
  localparam logic [YW-1:0] Y_LO = YW'(MARGIN);
  localparam logic [YW-1:0] Y_HI = YW'(Y_LIM - MARGIN);

  always_comb begin
    out_of_bounds = (x < X_LO) || (x > X_HI) || (y < Y_LO) || (y > Y_HI);
  end

endmodule : bounds_check

// File: rtl/nest_setup_ctrl.sv
// -----------------------------------------------------------------------------
// nest_setup_ctrl
// Setup-phase sequencer. It places NUM_NESTS nests one at a time. For each
// nest it pulls a candidate coordinate, probes the shared collide bus against
// the nests already placed and the obstacle map, and checks the edge margin.
// When the candidate is clean it commits it with a one-cycle SET strobe. If
// the per-nest retry budget runs out, the run stops in FAIL.
//
// Ports
//   setup_clk      in  1          clock, all state changes on the rising edge
//   RESET          in  1          synchronous reset, active low
//   start          in  1          pulse, starts a run from IDLE/DONE/FAIL
//   cand_x/cand_y  in  X/Y_bits   candidate coordinate
//   cand_valid     in  1          candidate present
//   cand_ready     out 1          high in FETCH; transfer on valid&&ready
//   collide_x/y    out X/Y_bits   registered probe coordinate to all nests
//   collision_vec  in  NUM_NESTS  per-nest collision result for the probe
//   obstacle_hit   in  1          wall/obstacle map result for the probe
//   in_x/in_y      out X/Y_bits   committed coordinate to all nests
//   SET            out NUM_NESTS  one-hot, one-cycle write strobe
//   SETUP_PHASE    out 1          high while a run is active
//   placed         out NUM_NESTS  nests committed in the current run
//   done           out 1          level, all nests placed
//   fail           out 1          level, retry budget exhausted
// -----------------------------------------------------------------------------
module nest_setup_ctrl
  import nest_setup_ctrl_pkg::*;
#(
  parameter int NUM_NESTS = 4,
  parameter int MAX_RETRY = 15
) (
  input  logic                 setup_clk,
  input  logic                 RESET,
  input  logic                 start,
  input  logic [X_bits-1:0]    cand_x,
  input  logic [Y_bits-1:0]    cand_y,
  input  logic                 cand_valid,
  output logic                 cand_ready,
  output logic [X_bits-1:0]    collide_x,
  output logic [Y_bits-1:0]    collide_y,
  input  logic [NUM_NESTS-1:0] collision_vec,
  input  logic                 obstacle_hit,
  output logic [X_bits-1:0]    in_x,
  output logic [Y_bits-1:0]    in_y,
  output logic [NUM_NESTS-1:0] SET,
  output logic                 SETUP_PHASE,
  output logic [NUM_NESTS-1:0] placed,
  output logic                 done,
  output logic                 fail
);

  localparam int IDX_W   = clog2_min1(NUM_NESTS);
  localparam int RETRY_W = clog2_min1(MAX_RETRY + 1);

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_NESTS - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

  nest_setup_state_t    state_q,       state_d;
  logic [IDX_W-1:0]     idx_q,         idx_d;
  logic [RETRY_W-1:0]   retry_q,       retry_d;
  logic                 cand_ready_q,  cand_ready_d;
  logic [X_bits-1:0]    collide_x_q,   collide_x_d;
  logic [Y_bits-1:0]    collide_y_q,   collide_y_d;
  logic [X_bits-1:0]    in_x_q,        in_x_d;
  logic [Y_bits-1:0]    in_y_q,        in_y_d;
  logic [NUM_NESTS-1:0] set_q,         set_d;
  logic                 setup_phase_q, setup_phase_d;
  logic [NUM_NESTS-1:0] placed_q,      placed_d;
  logic                 done_q,        done_d;
  logic                 fail_q,        fail_d;

  logic                 out_of_bounds;
  logic                 nest_hit;
  logic                 reject;
  logic [NUM_NESTS-1:0] idx_onehot;

  // The margin check works on the registered probe coordinate. That value is
  // stable from PROBE onward, so the result has settled by CHECK.
  bounds_check u_bounds_check (
    .x             (collide_x_q),
    .y             (collide_y_q),
    .out_of_bounds (out_of_bounds)
  );

  always_comb begin
    // Nests that are not yet placed still sit at (0,0) and may report a hit.
    // Only collisions with nests committed in this run count.
    nest_hit   = |(collision_vec & placed_q);
    reject     = nest_hit | obstacle_hit | out_of_bounds;
    idx_onehot = NUM_NESTS'(1) << idx_q;
  end

  always_comb begin
    // NOTE: every *_d starts from its *_q value, so no path through the case
    // leaves a variable unassigned. That is what keeps this block latch-free.
    state_d       = state_q;
    idx_d         = idx_q;
    retry_d       = retry_q;
    collide_x_d   = collide_x_q;
    collide_y_d   = collide_y_q;
    in_x_d        = in_x_q;
    in_y_d        = in_y_q;
    setup_phase_d = setup_phase_q;
    placed_d      = placed_q;
    done_d        = done_q;
    fail_d        = fail_q;
    // SET defaults low rather than holding, so it can only be high for the
    // single cycle after CHECK accepts.
    set_d         = '0;

    unique case (state_q)
      IDLE, DONE, FAIL: begin
        if (start) begin
          state_d       = FETCH;
          idx_d         = '0;
          retry_d       = '0;
          placed_d      = '0;
          setup_phase_d = 1'b1;
          done_d        = 1'b0;
          fail_d        = 1'b0;
        end
      end

      FETCH: begin
        // cand_ready_q is high throughout FETCH, so cand_valid alone marks
        // the transfer edge.
        if (cand_valid) begin
          collide_x_d = cand_x;
          collide_y_d = cand_y;
          state_d     = PROBE;
        end
      end

      PROBE: begin
        state_d = CHECK;
      end

      CHECK: begin
        if (reject) begin
          if (retry_q == RETRY_LIM) begin
            state_d       = FAIL;
            setup_phase_d = 1'b0;
            fail_d        = 1'b1;
          end else begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = FETCH;
          end
        end else begin
          in_x_d   = collide_x_q;
          in_y_d   = collide_y_q;
          set_d    = idx_onehot;
          placed_d = placed_q | idx_onehot;
          state_d  = COMMIT;
        end
      end

      COMMIT: begin
        retry_d = '0;
        if (idx_q == LAST_IDX) begin
          state_d       = DONE;
          setup_phase_d = 1'b0;
          done_d        = 1'b1;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = FETCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered ready. It follows the state being entered, so it is high
    // exactly while the machine sits in FETCH.
    cand_ready_d = (state_d == FETCH);
  end

  // NOTE: state uses non-blocking assignments, so every flop samples the
  // pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge setup_clk) begin
    if (!RESET) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      retry_q       <= '0;
      cand_ready_q  <= 1'b0;
      collide_x_q   <= '0;
      collide_y_q   <= '0;
      in_x_q        <= '0;
      in_y_q        <= '0;
      set_q         <= '0;
      setup_phase_q <= 1'b0;
      placed_q      <= '0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      retry_q       <= retry_d;
      cand_ready_q  <= cand_ready_d;
      collide_x_q   <= collide_x_d;
      collide_y_q   <= collide_y_d;
      in_x_q        <= in_x_d;
      in_y_q        <= in_y_d;
      set_q         <= set_d;
      setup_phase_q <= setup_phase_d;
      placed_q      <= placed_d;
      done_q        <= done_d;
      fail_q        <= fail_d;
    end
  end

  assign cand_ready  = cand_ready_q;
  assign collide_x   = collide_x_q;
  assign collide_y   = collide_y_q;
  assign in_x        = in_x_q;
  assign in_y        = in_y_q;
  assign SET         = set_q;
  assign SETUP_PHASE = setup_phase_q;
  assign placed      = placed_q;
  assign done        = done_q;
  assign fail        = fail_q;

endmodule : nest_setup_ctrl

// File: tb/tb_nest_setup_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nest_setup_ctrl
// Scoreboard bench for nest_setup_ctrl. Each time a candidate is handed over,
// a small reference model decides whether the candidate will be accepted. An
// accepted candidate is queued as an expected {nest, x, y} commit. A monitor
// pops the queue on every SET pulse.
// -----------------------------------------------------------------------------
module tb_nest_setup_ctrl;
  import nest_setup_ctrl_pkg::*;

  localparam int NN = 4;
  localparam int MR = 15;
  localparam int IW = $clog2(NN);

  logic              setup_clk = 1'b0;
  logic              RESET;
  logic              start;
  logic [X_bits-1:0] cand_x;
  logic [Y_bits-1:0] cand_y;
  logic              cand_valid;
  logic              cand_ready;
  logic [X_bits-1:0] collide_x;
  logic [Y_bits-1:0] collide_y;
  logic [NN-1:0]     collision_vec;
  logic              obstacle_hit;
  logic [X_bits-1:0] in_x;
  logic [Y_bits-1:0] in_y;
  logic [NN-1:0]     SET;
  logic              SETUP_PHASE;
  logic [NN-1:0]     placed;
  logic              done;
  logic              fail;

  always #5 setup_clk = ~setup_clk;

  nest_setup_ctrl #(
    .NUM_NESTS (NN),
    .MAX_RETRY (MR)
  ) dut (
    .setup_clk     (setup_clk),
    .RESET         (RESET),
    .start         (start),
    .cand_x        (cand_x),
    .cand_y        (cand_y),
    .cand_valid    (cand_valid),
    .cand_ready    (cand_ready),
    .collide_x     (collide_x),
    .collide_y     (collide_y),
    .collision_vec (collision_vec),
    .obstacle_hit  (obstacle_hit),
    .in_x          (in_x),
    .in_y          (in_y),
    .SET           (SET),
    .SETUP_PHASE   (SETUP_PHASE),
    .placed        (placed),
    .done          (done),
    .fail          (fail)
  );

  typedef struct packed {
    logic [IW-1:0]     idx;
    logic [X_bits-1:0] x;
    logic [Y_bits-1:0] y;
  } commit_t;

  commit_t exp_q[$];
  commit_t mon_e;

  int n_vec   = 0;
  int n_err   = 0;
  int n_set   = 0;
  int n_hs    = 0;
  int cyc     = 0;
  int t_start = 0;

  // Reference model state for the current run.
  logic [NN-1:0] m_placed;
  int            m_idx;
  int            m_retry;

  always @(posedge setup_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // The model rejects a candidate that hits a placed nest, hits an obstacle,
  // or lies within NEST_RADIUS of an edge.
  function automatic bit model_reject(input int x, input int y,
                                      input logic [NN-1:0] coll, input bit obs);
    bit hit_nest;
    bit oob;
    hit_nest = ((coll & m_placed) != '0);
    oob      = (x < NEST_RADIUS) || (x > X_MAX - NEST_RADIUS) ||
               (y < NEST_RADIUS) || (y > Y_MAX - NEST_RADIUS);
    return hit_nest || obs || oob;
  endfunction

  // Every SET pulse must match the oldest outstanding expected commit.
  always @(negedge setup_clk) begin
    if (SET != '0) begin
      n_set++;
      if (exp_q.size() == 0) begin
        check("unexpected_set", 32'(SET), 32'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("set_onehot", 32'(SET), 32'(1) << mon_e.idx);
        check("in_x",       32'(in_x), 32'(mon_e.x));
        check("in_y",       32'(in_y), 32'(mon_e.y));
        check("set_phase",  32'(SETUP_PHASE), 32'(1));
      end
    end
  end

  // Present one candidate and wait, within a bounded time, for the transfer.
  // The side inputs stay as they are for `hold` further cycles so that they
  // cover PROBE and CHECK.
  task automatic send(input int x, input int y, input logic [NN-1:0] coll,
                      input bit obs, input int hold);
    int waited;
    waited        = 0;
    cand_x        = X_bits'(x);
    cand_y        = Y_bits'(y);
    collision_vec = coll;
    obstacle_hit  = obs;
    cand_valid    = 1'b1;
    @(negedge setup_clk);
    while (!cand_ready && waited < 80) begin
      @(negedge setup_clk);
      waited++;
    end
    if (!cand_ready) begin
      check("handshake_timeout", 32'(0), 32'(1));
      cand_valid = 1'b0;
      return;
    end
    @(posedge setup_clk);
    #1;
    cand_valid = 1'b0;
    n_hs++;
    if (model_reject(x, y, coll, obs)) begin
      m_retry++;
    end else begin
      exp_q.push_back(commit_t'{idx: IW'(m_idx), x: X_bits'(x), y: Y_bits'(y)});
      m_placed[m_idx] = 1'b1;
      m_idx++;
      m_retry = 0;
    end
    repeat (hold) begin
      @(posedge setup_clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge setup_clk);
    #1;
    start    = 1'b0;
    t_start  = cyc;
    m_placed = '0;
    m_idx    = 0;
    m_retry  = 0;
  endtask

  task automatic wait_end(output int lat);
    int n;
    n = 0;
    while (!(done || fail) && n < 300) begin
      @(negedge setup_clk);
      n++;
    end
    if (!(done || fail)) check("end_timeout", 32'(0), 32'(1));
    lat = cyc - t_start;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_set"},     32'(SET), 32'(0));
    check({tag, "_phase"},   32'(SETUP_PHASE), 32'(0));
    check({tag, "_placed"},  32'(placed), 32'(0));
    check({tag, "_ready"},   32'(cand_ready), 32'(0));
    check({tag, "_cx"},      32'(collide_x), 32'(0));
    check({tag, "_cy"},      32'(collide_y), 32'(0));
    check({tag, "_inx"},     32'(in_x), 32'(0));
    check({tag, "_iny"},     32'(in_y), 32'(0));
    check({tag, "_done"},    32'(done), 32'(0));
    check({tag, "_fail"},    32'(fail), 32'(0));
  endtask

  task automatic end_checks(input string tag, input int lat, input int exp_lat,
                            input int set0, input int exp_sets);
    if (exp_lat >= 0) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_done"},     32'(done), 32'(1));
    check({tag, "_fail"},     32'(fail), 32'(0));
    check({tag, "_placed"},   32'(placed), 32'(4'hf));
    check({tag, "_phase"},    32'(SETUP_PHASE), 32'(0));
    check({tag, "_sets"},     32'(n_set - set0), 32'(exp_sets));
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int set0;
    int hs0;
    RESET         = 1'b0;
    start         = 1'b0;
    cand_valid    = 1'b0;
    cand_x        = '0;
    cand_y        = '0;
    collision_vec = '0;
    obstacle_hit  = 1'b0;
    m_placed      = '0;
    m_idx         = 0;
    m_retry       = 0;

    repeat (3) @(posedge setup_clk);
    #1;
    check_cleared("por");
    RESET = 1'b1;
    @(posedge setup_clk);
    #1;

    // Clean run: four accepts back to back, done 16 cycles after start.
    set0 = n_set;
    pulse_start();
    check("clean_phase_on", 32'(SETUP_PHASE), 32'(1));
    send(100, 100, '0, 1'b0, 0);
    send(300, 100, '0, 1'b0, 0);
    send(100, 300, '0, 1'b0, 0);
    send(300, 300, '0, 1'b0, 0);
    wait_end(lat);
    end_checks("clean", lat, 16, set0, 4);

    // Collision masking: a hit from unplaced nest 1 is ignored for nest 0,
    // but the same vector rejects once nest 1 is placed.
    set0 = n_set;
    hs0  = n_hs;
    pulse_start();
    send(100, 100, 4'b0010, 1'b0, 2);
    send(300, 100, 4'b0000, 1'b0, 0);
    send(100, 300, 4'b0010, 1'b0, 2);
    send(100, 300, 4'b0000, 1'b0, 0);
    send(300, 300, 4'b0000, 1'b0, 0);
    wait_end(lat);
    end_checks("mask", lat, 19, set0, 4);
    check("mask_fetches", 32'(n_hs - hs0), 32'(5));

    // Bounds: each edge one step inside the margin is rejected, and the
    // margin itself is accepted. A start pulse mid-run must be ignored.
    set0 = n_set;
    pulse_start();
    send(NEST_RADIUS - 1, 100, '0, 1'b0, 2);
    start = 1'b1;
    @(posedge setup_clk);
    #1;
    start = 1'b0;
    check("busy_start_ready", 32'(cand_ready), 32'(1));
    check("busy_start_phase", 32'(SETUP_PHASE), 32'(1));
    send(NEST_RADIUS, 100, '0, 1'b0, 0);
    send(X_MAX - NEST_RADIUS + 1, 100, '0, 1'b0, 2);
    send(X_MAX - NEST_RADIUS, 100, '0, 1'b0, 0);
    send(200, Y_MAX - NEST_RADIUS + 1, '0, 1'b0, 2);
    send(200, Y_MAX - NEST_RADIUS, '0, 1'b0, 0);
    send(300, NEST_RADIUS - 1, '0, 1'b0, 2);
    send(300, NEST_RADIUS, '0, 1'b0, 0);
    wait_end(lat);
    end_checks("bounds", lat, 16 + 4 * 3 + 1, set0, 4);

    // Handshake stall: cand_valid stays low for 5 cycles while in FETCH.
    set0 = n_set;
    pulse_start();
    send(100, 100, '0, 1'b0, 0);
    begin
      int w;
      w = 0;
      while (!cand_ready && w < 20) begin
        @(negedge setup_clk);
        w++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge setup_clk);
      #1;
      check("stall_ready", 32'(cand_ready), 32'(1));
    end
    check("stall_collide_x", 32'(collide_x), 32'(100));
    send(300, 100, '0, 1'b0, 0);
    send(100, 300, '0, 1'b0, 0);
    send(300, 300, '0, 1'b0, 0);
    wait_end(lat);
    end_checks("stall", lat, 21, set0, 4);

    // Retry exhaustion: 16 obstacle hits, then FAIL with no SET.
    set0 = n_set;
    hs0  = n_hs;
    pulse_start();
    for (int i = 0; i < MR; i++) send(200 + i, 200, '0, 1'b1, 2);
    check("retry_not_yet_fail", 32'(fail), 32'(0));
    check("retry_still_ready",  32'(cand_ready), 32'(1));
    send(250, 250, '0, 1'b1, 2);
    wait_end(lat);
    check("retry_fail",     32'(fail), 32'(1));
    check("retry_done",     32'(done), 32'(0));
    check("retry_phase",    32'(SETUP_PHASE), 32'(0));
    check("retry_placed",   32'(placed), 32'(0));
    check("retry_ready",    32'(cand_ready), 32'(0));
    check("retry_fetches",  32'(n_hs - hs0), 32'(MR + 1));
    check("retry_sets",     32'(n_set - set0), 32'(0));
    check("retry_sb_empty", 32'(exp_q.size()), 32'(0));

    // Reset on the edge that would enter COMMIT for nest 2.
    set0 = n_set;
    pulse_start();
    check("refail_start_fail", 32'(fail), 32'(0));
    send(100, 100, '0, 1'b0, 0);
    send(300, 100, '0, 1'b0, 0);
    send(100, 300, '0, 1'b0, 0);
    @(posedge setup_clk);
    #1;
    RESET = 1'b0;
    @(posedge setup_clk);
    #1;
    exp_q.delete();
    check_cleared("mid_rst");
    check("mid_rst_sets", 32'(n_set - set0), 32'(2));
    repeat (2) begin
      @(posedge setup_clk);
      #1;
      check("mid_rst_hold_set", 32'(SET), 32'(0));
    end
    RESET = 1'b1;
    @(posedge setup_clk);
    #1;
    set0 = n_set;
    pulse_start();
    check("post_rst_placed", 32'(placed), 32'(0));
    check("post_rst_phase",  32'(SETUP_PHASE), 32'(1));
    send(120, 120, '0, 1'b0, 0);
    send(320, 120, '0, 1'b0, 0);
    send(120, 320, '0, 1'b0, 0);
    send(320, 320, '0, 1'b0, 0);
    wait_end(lat);
    end_checks("post_rst", lat, 16, set0, 4);

    repeat (2) @(posedge setup_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_nest_setup_ctrl
